fifo_drain_arbiter: RTL and testbench

FIFO_DRAIN_ARBITER -- requirements
Module: fifo_drain_arbiter

---
 rtl/dagger_pkg.sv | 13 +
 rtl/skid_buffer_2.sv | 57 +++++
 rtl/fifo_drain_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_fifo_drain_arbiter.sv | 474 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dagger_pkg.sv
// dagger_pkg: definitions shared by the FIFO drain arbiter and its helpers.
//   arb_state_e : arbiter FSM state (IDLE searches for a channel, BURST drains it)
//   BURST_W     : width of the per-grant pop counter (MAX_BURST is at most 255)
package dagger_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_e;

  localparam int unsigned BURST_W = 8;

endpackage

// File: rtl/skid_buffer_2.sv
// skid_buffer_2: two-entry FIFO between the channel read path and the
// downstream valid/ready interface.
//   clk, rst_n : clock and asynchronous active-low reset
//   in_valid   : write strobe; in_data is captured on the same edge
//   in_data    : write payload
//   out_valid  : head entry present (count != 0)
//   out_ready  : downstream accept; a beat leaves on out_valid & out_ready
//   out_data   : head entry, forced to zero while the buffer is empty
//   count      : occupancy, 0..2
// A write and a read in the same cycle leave count unchanged. A write into a
// full buffer without a read is dropped; the arbiter's credit check keeps
// that from happening.
module skid_buffer_2 #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            count
);

  logic [DATA_WIDTH-1:0] mem_p0 [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic                  enq;
  logic                  deq;

  assign out_valid = (count != 2'd0);
  assign deq       = out_valid & out_ready;
  assign enq       = in_valid & ((count != 2'd2) | deq);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      wr_ptr <= wr_ptr ^ enq;
      rd_ptr <= rd_ptr ^ deq;
      count  <= count + 2'(enq) - 2'(deq);
    end
  end

  // Storage stage: payload registers carry no reset; emptiness masks them.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem_p0[wr_ptr] <= in_data;
    end
  end

  assign out_data = out_valid ? mem_p0[rd_ptr] : '0;

endmodule

// File: rtl/fifo_drain_arbiter.sv
// fifo_drain_arbiter: drains NUM_CH asynchronous FIFOs (read side on clk) into
// a single valid/ready stream, granting channels round-robin with up to
// MAX_BURST pops per grant.
//   clk, rst_n    : read-side clock, asynchronous active-low reset
//   ch_empty      : per-channel FIFO empty flags
//   ch_pop_en     : per-channel pop request (at most one bit set)
//   ch_pop_valid  : per-channel read-data valid, one cycle after a pop
//   ch_pop_data   : per-channel read data
//   ch_error      : per-channel sticky write-side loss flags
//   out_valid/out_ready/out_data/out_ch_id : output beat and its source channel
//   err_lost      : ch_error delayed by one cycle
//   err_protocol  : sticky; a channel returned data it was not asked for
module fifo_drain_arbiter #(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 8
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_CH-1:0]                  ch_empty,
  output logic [NUM_CH-1:0]                  ch_pop_en,
  input  logic [NUM_CH-1:0]                  ch_pop_valid,
  input  logic [NUM_CH-1:0][DATA_WIDTH-1:0]  ch_pop_data,
  input  logic [NUM_CH-1:0]                  ch_error,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [DATA_WIDTH-1:0]              out_data,
  output logic [$clog2(NUM_CH)-1:0]          out_ch_id,
  output logic [NUM_CH-1:0]                  err_lost,
  output logic                               err_protocol
);

  import dagger_pkg::*;

  localparam int ID_W   = $clog2(NUM_CH);
  localparam int SKID_W = DATA_WIDTH + ID_W;

  arb_state_e         state_q, state_nxt;
  logic [ID_W-1:0]    grant_q, grant_nxt;
  logic [ID_W-1:0]    last_grant_q, last_grant_nxt;
  logic [BURST_W-1:0] burst_cnt_q, burst_cnt_nxt;
  logic               rr_hit;
  logic [ID_W-1:0]    rr_pick;
  logic               pop;
  logic               credit;
  logic [2:0]         occ_net;

  logic               pop_vld_p1;
  logic [ID_W-1:0]    grant_p1;
  logic [NUM_CH-1:0]  pop_en_p1;
  logic               live_p1;

  logic               skid_valid;
  logic [SKID_W-1:0]  skid_in;
  logic [SKID_W-1:0]  skid_out;
  logic [1:0]         skid_count;
  logic               deq;

  // First non-empty channel after 'last', wrapping modulo NUM_CH.
  // Returns {hit, index}.
  function automatic logic [ID_W:0] rr_search(input logic [NUM_CH-1:0] empty,
                                                input logic [ID_W-1:0]   last);
    logic [ID_W:0]   res;
    logic [ID_W-1:0] cand;
    int unsigned     pos;
    res = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      pos = int'(last) + k;
      if (pos >= NUM_CH) pos = pos - NUM_CH;
      cand = ID_W'(pos);
      if (!res[ID_W] && !empty[cand]) res = {1'b1, cand};
    end
    return res;
  endfunction

  assign deq = skid_valid & out_ready;

  // Occupancy the skid buffer will hold once this cycle's departing beat
  // and the beat already in flight are accounted for. A pop now lands in
  // the buffer two edges from now, so it is safe exactly when this is < 2;
  // counting the departing beat is what lets a burst run at one beat per
  // cycle with out_ready held high.
  assign occ_net = 3'(skid_count) - 3'(deq) + 3'(pop_vld_p1);
  assign credit  = (occ_net < 3'd2);

  always_comb begin
    state_nxt      = state_q;
    grant_nxt      = grant_q;
    last_grant_nxt = last_grant_q;
    burst_cnt_nxt  = burst_cnt_q;
    ch_pop_en      = '0;
    pop            = 1'b0;
    {rr_hit, rr_pick} = rr_search(ch_empty, last_grant_q);

    unique case (state_q)
      ST_IDLE: begin
        if (rr_hit) begin
          grant_nxt     = rr_pick;
          burst_cnt_nxt = '0;
          state_nxt     = ST_BURST;
        end
      end
      ST_BURST: begin
        if (!ch_empty[grant_q] && credit) begin
          pop                = 1'b1;
          ch_pop_en[grant_q] = 1'b1;
          burst_cnt_nxt      = burst_cnt_q + 1'b1;
          if (burst_cnt_q == BURST_W'(MAX_BURST - 1)) begin
            state_nxt      = ST_IDLE;
            last_grant_nxt = grant_q;
          end
        end else if (ch_empty[grant_q]) begin
          state_nxt      = ST_IDLE;
          last_grant_nxt = grant_q;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= ID_W'(NUM_CH - 1);
      burst_cnt_q  <= '0;
    end else begin
      state_q      <= state_nxt;
      grant_q      <= grant_nxt;
      last_grant_q <= last_grant_nxt;
      burst_cnt_q  <= burst_cnt_nxt;
    end
  end

  // Pop -> read-data stage: remember which channel was popped so the
  // returning word can be steered and tagged, and so unsolicited valids
  // can be detected.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pop_vld_p1   <= 1'b0;
      grant_p1     <= '0;
      pop_en_p1    <= '0;
      live_p1      <= 1'b0;
      err_protocol <= 1'b0;
      err_lost     <= '0;
    end else begin
      pop_vld_p1 <= pop;
      grant_p1   <= grant_q;
      pop_en_p1  <= ch_pop_en;
      // live_p1 masks the first cycle out of reset, when a channel may
      // still answer a pop that the reset cancelled.
      live_p1    <= 1'b1;
      if (live_p1 && |(ch_pop_valid & ~pop_en_p1)) begin
        err_protocol <= 1'b1;
      end
      err_lost <= ch_error;
    end
  end

  // Read-data -> skid stage: the word returned for the popped channel is
  // written with its channel id one cycle after the pop.
  assign skid_in = {grant_p1, ch_pop_data[grant_p1]};

  skid_buffer_2 #(
    .DATA_WIDTH (SKID_W)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (pop_vld_p1),
    .in_data   (skid_in),
    .out_valid (skid_valid),
    .out_ready (out_ready),
    .out_data  (skid_out),
    .count     (skid_count)
  );

  assign out_valid = skid_valid;
  assign out_data  = skid_out[DATA_WIDTH-1:0];
  assign out_ch_id = skid_out[SKID_W-1 -: ID_W];

endmodule

// File: tb/tb_fifo_drain_arbiter.sv
// tb_fifo_drain_arbiter: emulates NUM_CH channel FIFOs around the arbiter and
// compares the output stream against a queue-based round-robin model.
module tb_fifo_drain_arbiter;

  localparam int NUM_CH = 4;
  localparam int DW     = 32;
  localparam int MB     = 8;
  localparam int IDW    = $clog2(NUM_CH);

  typedef struct {
    int            ch;
    logic [DW-1:0] data;
    int            cyc;
  } beat_t;

  typedef struct {
    int            ch;
    logic [DW-1:0] data;
    int            gap;
  } exp_t;

  logic                        clk = 1'b0;
  logic                        rst_n;
  logic [NUM_CH-1:0]           ch_empty;
  logic [NUM_CH-1:0]           ch_pop_en;
  logic [NUM_CH-1:0]           ch_pop_valid;
  logic [NUM_CH-1:0][DW-1:0]   ch_pop_data;
  logic [NUM_CH-1:0]           ch_error;
  logic                        out_valid;
  logic                        out_ready;
  logic [DW-1:0]               out_data;
  logic [IDW-1:0]              out_ch_id;
  logic [NUM_CH-1:0]           err_lost;
  logic                        err_protocol;

  fifo_drain_arbiter #(
    .NUM_CH     (NUM_CH),
    .DATA_WIDTH (DW),
    .MAX_BURST  (MB)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ch_empty     (ch_empty),
    .ch_pop_en    (ch_pop_en),
    .ch_pop_valid (ch_pop_valid),
    .ch_pop_data  (ch_pop_data),
    .ch_error     (ch_error),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_ch_id    (out_ch_id),
    .err_lost     (err_lost),
    .err_protocol (err_protocol)
  );

  always #5 clk = ~clk;

  logic [DW-1:0]     chq [NUM_CH][$];
  beat_t             obs[$];
  exp_t              expq[$];
  int                pop_cyc[$];
  int                cyc = 0;
  int                n_pop = 0;
  int                n_acc = 0;
  int                stall_cnt = 0;
  bit                rand_ready = 0;
  logic [NUM_CH-1:0] spur_mask = '0;
  bit                prev_hold = 0;
  logic [DW-1:0]     prev_data;
  logic [IDW-1:0]    prev_id;
  int                checks = 0;
  int                errors = 0;

  function automatic bit all_empty();
    for (int i = 0; i < NUM_CH; i++) if (chq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic load(input int ch, input int n);
    for (int j = 0; j < n; j++) chq[ch].push_back($urandom());
    ch_empty[ch] = (chq[ch].size() == 0);
  endtask

  // One clock: sample at the falling edge, then play the channel side of
  // the edge (pop the queue, return data with valid on the next cycle).
  task automatic cycle();
    logic [NUM_CH-1:0] pe;
    @(negedge clk);
    pe = ch_pop_en;
    checks++;
    if (!$onehot0(pe) || ((pe & ch_empty) != '0)) begin
      errors++;
      $display("FAIL pop_en cyc=%0d got pop_en=%b with ch_empty=%b, required at most one pop on a non-empty channel",
               cyc, pe, ch_empty);
    end
    if (prev_hold) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== prev_data || out_ch_id !== prev_id) begin
        errors++;
        $display("FAIL hold_stable cyc=%0d got valid=%b data=%h id=%0d, required valid=1 data=%h id=%0d",
                 cyc, out_valid, out_data, out_ch_id, prev_data, prev_id);
      end
    end
    if (pe != '0) begin
      n_pop++;
      pop_cyc.push_back(cyc);
    end
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      n_acc++;
      obs.push_back('{int'(out_ch_id), out_data, cyc});
    end
    checks++;
    if (n_pop - n_acc > 2) begin
      errors++;
      $display("FAIL outstanding cyc=%0d got %0d pops not yet delivered, required <= 2", cyc, n_pop - n_acc);
    end
    prev_hold = (out_valid === 1'b1) && (out_ready === 1'b0);
    prev_data = out_data;
    prev_id   = out_ch_id;
    @(posedge clk);
    #1;
    cyc++;
    ch_pop_valid = spur_mask;
    spur_mask    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_pop_data[i] = $urandom();
      if (pe[i] && chq[i].size() > 0) begin
        ch_pop_data[i]  = chq[i].pop_front();
        ch_pop_valid[i] = 1'b1;
      end
      ch_empty[i] = (chq[i].size() == 0);
    end
    if (stall_cnt > 0) begin
      out_ready = 1'b0;
      stall_cnt--;
    end else begin
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  endtask

  task automatic clear_tracking();
    obs.delete();
    pop_cyc.delete();
    n_pop     = 0;
    n_acc     = 0;
    prev_hold = 0;
    stall_cnt = 0;
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    ch_pop_valid = '0;
    spur_mask    = '0;
    ch_error     = '0;
    out_ready    = 1'b1;
    rand_ready   = 0;
    for (int i = 0; i < NUM_CH; i++) chq[i].delete();
    ch_empty = '1;
    clear_tracking();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Round-robin model: from the channel after the last grant, take the
  // first channel holding words and drain min(words, MB) of them. The gap
  // before a burst's first beat is 2 cycles after a full burst (one IDLE
  // cycle) and 3 after a short one (empty-detect cycle plus IDLE cycle).
  task automatic build_expected();
    logic [DW-1:0] cp [NUM_CH][$];
    int lg, pos, n, prev_n, c, left;
    expq.delete();
    lg     = NUM_CH - 1;
    prev_n = MB;
    left   = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      cp[i] = chq[i];
      left += cp[i].size();
    end
    while (left > 0) begin
      pos = -1;
      for (int k = 1; k <= NUM_CH; k++) begin
        c = (lg + k) % NUM_CH;
        if (pos < 0 && cp[c].size() > 0) pos = c;
      end
      n = (cp[pos].size() < MB) ? cp[pos].size() : MB;
      for (int j = 0; j < n; j++)
        expq.push_back('{pos, cp[pos].pop_front(), (j == 0) ? ((prev_n == MB) ? 2 : 3) : 1});
      left  -= n;
      prev_n = n;
      lg     = pos;
    end
  endtask

  task automatic run_drain(input string name, input int budget);
    int n = 0;
    while (n < budget && !(obs.size() >= expq.size() && all_empty() && out_valid !== 1'b1)) begin
      cycle();
      n++;
    end
    repeat (3) cycle();
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s_timeout got %0d beats after %0d cycles, required %0d", name, obs.size(), n, expq.size());
    end
  endtask

  task automatic compare_seq(input string name);
    int m;
    checks++;
    if (obs.size() != expq.size()) begin
      errors++;
      $display("FAIL %s_count got %0d beats, required %0d", name, obs.size(), expq.size());
    end
    m = (obs.size() < expq.size()) ? obs.size() : expq.size();
    for (int k = 0; k < m; k++) begin
      checks++;
      if (obs[k].ch != expq[k].ch || obs[k].data !== expq[k].data) begin
        errors++;
        $display("FAIL %s_beat%0d got ch=%0d data=%h, required ch=%0d data=%h",
                 name, k, obs[k].ch, obs[k].data, expq[k].ch, expq[k].data);
      end
    end
  endtask

  task automatic check_timing(input string name);
    int m;
    checks++;
    if (obs.size() == 0 || pop_cyc.size() == 0) begin
      errors++;
      $display("FAIL %s_latency got %0d beats and %0d pops, required both non-zero", name, obs.size(), pop_cyc.size());
    end else if (obs[0].cyc != pop_cyc[0] + 2) begin
      errors++;
      $display("FAIL %s_latency got first beat %0d cycles after first pop, required 2", name, obs[0].cyc - pop_cyc[0]);
    end
    m = (obs.size() < expq.size()) ? obs.size() : expq.size();
    for (int k = 1; k < m; k++) begin
      checks++;
      if (obs[k].cyc - obs[k-1].cyc != expq[k].gap) begin
        errors++;
        $display("FAIL %s_gap%0d got %0d cycles between beats, required %0d",
                 name, k, obs[k].cyc - obs[k-1].cyc, expq[k].gap);
      end
    end
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    ch_empty     = '1;
    ch_pop_valid = '0;
    ch_pop_data  = '0;
    ch_error     = '1;
    out_ready    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (ch_pop_en !== '0 || out_valid !== 1'b0 || out_data !== '0 || out_ch_id !== '0) begin
      errors++;
      $display("FAIL reset_outputs got pop_en=%b valid=%b data=%h id=%0d, required all zero",
               ch_pop_en, out_valid, out_data, out_ch_id);
    end
    checks++;
    if (err_lost !== '0 || err_protocol !== 1'b0) begin
      errors++;
      $display("FAIL reset_errors got err_lost=%b err_protocol=%b, required 0 and 0", err_lost, err_protocol);
    end
    do_reset();
    repeat (3) cycle();
    checks++;
    if (out_valid !== 1'b0 || ch_pop_en !== '0) begin
      errors++;
      $display("FAIL idle_empty got valid=%b pop_en=%b, required 0 with all channels empty", out_valid, ch_pop_en);
    end
  endtask

  task automatic test_single_burst();
    do_reset();
    chq[0].push_back(32'hA000_000A);
    chq[0].push_back(32'hB000_000B);
    chq[0].push_back(32'hC000_000C);
    ch_empty[0] = 1'b0;
    build_expected();
    run_drain("single", 100);
    compare_seq("single");
    check_timing("single");
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < NUM_CH; i++) load(i, 20);
    build_expected();
    run_drain("rr", 400);
    compare_seq("rr");
    check_timing("rr");
  endtask

  task automatic test_backpressure();
    do_reset();
    load(0, 6);
    load(1, 12);
    build_expected();
    repeat (5) cycle();
    stall_cnt = 10;
    run_drain("bp", 400);
    compare_seq("bp");
  endtask

  task automatic test_early_empty();
    do_reset();
    load(2, 3);
    load(3, 5);
    build_expected();
    run_drain("early", 200);
    compare_seq("early");
    check_timing("early");
    checks++;
    if (obs.size() < 4 || obs[2].ch != 2 || obs[3].ch != 3) begin
      errors++;
      $display("FAIL early_handover got %0d beats (beat2/3 ch %0d/%0d), required ch2 x3 then ch3",
               obs.size(), (obs.size() > 2) ? obs[2].ch : -1, (obs.size() > 3) ? obs[3].ch : -1);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      do_reset();
      for (int i = 0; i < NUM_CH; i++) load(i, $urandom_range(0, 20));
      rand_ready = 1;
      build_expected();
      run_drain("rand", 2000);
      compare_seq("rand");
    end
  endtask

  task automatic test_protocol_error();
    do_reset();
    repeat (3) cycle();
    spur_mask = 4'b0010;
    cycle();
    checks++;
    if (err_protocol !== 1'b0) begin
      errors++;
      $display("FAIL proto_before got err_protocol=%b, required 0", err_protocol);
    end
    cycle();
    checks++;
    if (err_protocol !== 1'b1) begin
      errors++;
      $display("FAIL proto_set got err_protocol=%b, required 1", err_protocol);
    end
    repeat (5) cycle();
    checks++;
    if (err_protocol !== 1'b1) begin
      errors++;
      $display("FAIL proto_sticky got err_protocol=%b, required 1", err_protocol);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (err_protocol !== 1'b0) begin
      errors++;
      $display("FAIL proto_reset got err_protocol=%b, required 0", err_protocol);
    end
  endtask

  task automatic test_err_lost();
    logic [NUM_CH-1:0] v, prev;
    do_reset();
    prev = '0;
    for (int it = 0; it < 5; it++) begin
      v = NUM_CH'($urandom());
      ch_error = v;
      @(negedge clk);
      checks++;
      if (err_lost !== prev) begin
        errors++;
        $display("FAIL err_lost_hold got %b, required %b", err_lost, prev);
      end
      @(posedge clk);
      #1;
      checks++;
      if (err_lost !== v) begin
        errors++;
        $display("FAIL err_lost_copy got %b, required %b", err_lost, v);
      end
      prev = v;
    end
    ch_error = '0;
  endtask

  task automatic test_reset_mid_burst();
    int n = 0;
    int m;
    do_reset();
    load(0, 12);
    load(1, 10);
    build_expected();
    while (n < 200 && obs.size() < 10) begin
      cycle();
      n++;
    end
    checks++;
    if (obs.size() < 10) begin
      errors++;
      $display("FAIL midrst_progress got %0d beats, required 10", obs.size());
    end
    m = (obs.size() < expq.size()) ? obs.size() : expq.size();
    for (int k = 0; k < m; k++) begin
      checks++;
      if (obs[k].ch != expq[k].ch || obs[k].data !== expq[k].data) begin
        errors++;
        $display("FAIL midrst_pre%0d got ch=%0d data=%h, required ch=%0d data=%h",
                 k, obs[k].ch, obs[k].data, expq[k].ch, expq[k].data);
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (ch_pop_en !== '0 || out_valid !== 1'b0 || out_data !== '0 || out_ch_id !== '0 ||
        err_lost !== '0 || err_protocol !== 1'b0) begin
      errors++;
      $display("FAIL midrst_outputs got pop_en=%b valid=%b data=%h id=%0d lost=%b proto=%b, required all zero",
               ch_pop_en, out_valid, out_data, out_ch_id, err_lost, err_protocol);
    end
    ch_pop_valid = '0;
    clear_tracking();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n          = 1'b1;
    ch_pop_valid   = 4'b0010;
    ch_pop_data[1] = $urandom();
    @(posedge clk);
    #1;
    ch_pop_valid = '0;
    build_expected();
    run_drain("midrst", 400);
    compare_seq("midrst");
    checks++;
    if (err_protocol !== 1'b0) begin
      errors++;
      $display("FAIL midrst_proto got err_protocol=%b, required 0", err_protocol);
    end
    checks++;
    if (obs.size() == 0 || obs[0].ch != 0) begin
      errors++;
      $display("FAIL midrst_restart got first ch=%0d, required 0", (obs.size() > 0) ? obs[0].ch : -1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got no completion by %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_burst();
    test_round_robin();
    test_backpressure();
    test_early_empty();
    test_random();
    test_protocol_error();
    test_err_lost();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
